// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the next PC, issues in-order instruction
// memory requests, buffers the returned words with their PC, and presents
// them to decode over a valid/ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0] pend_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] inst_cnt;
    logic [PTR_W-1:0] pend_wr;
    logic [PTR_W-1:0] pend_rd;
    logic [PTR_W-1:0] inst_wr;
    logic [PTR_W-1:0] inst_rd;

    logic [31:0] pend_mem      [FIFO_DEPTH];
    logic [31:0] inst_pc_mem   [FIFO_DEPTH];
    logic [31:0] inst_data_mem [FIFO_DEPTH];

    logic [CNT_W:0] occupancy;
    logic           has_credit;
    logic           req_fire;
    logic           rsp_take;
    logic           rsp_keep;
    logic           inst_pop;

    // Request issue, response classification and next-PC selection
    always_comb begin
        occupancy      = {1'b0, pend_cnt} + {1'b0, inst_cnt};
        has_credit     = occupancy < {1'b0, DEPTH_C};
        imem_req_valid = !rst && !redirect_valid && has_credit && (drop_cnt == '0);
        imem_req_addr  = pc_cur;
        req_fire       = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding belong to fetches abandoned by reset.
        rsp_take       = !rst && imem_rsp_valid && ((pend_cnt != '0) || (drop_cnt != '0));
        rsp_keep       = rsp_take && (drop_cnt == '0) && !redirect_valid;
        inst_valid     = (inst_cnt != '0);
        inst_pop       = inst_valid && inst_ready && !redirect_valid;
        inst_data      = inst_data_mem[inst_rd];
        inst_pc        = inst_pc_mem[inst_rd];
        pc_next        = pc_cur;
        if (rst)
            pc_next = RESET_PC;
        else if (redirect_valid)
            pc_next = redirect_pc;
        else if (req_fire)
            pc_next = pc_cur + 32'd4;
    end

    // Counters and FIFO pointers; redirect converts outstanding fetches to drops
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt <= '0;
            drop_cnt <= '0;
            inst_cnt <= '0;
            pend_wr  <= '0;
            pend_rd  <= '0;
            inst_wr  <= '0;
            inst_rd  <= '0;
        end else begin
            pend_wr <= pend_wr + PTR_W'(req_fire);
            pend_rd <= pend_rd + PTR_W'(rsp_take);
            if (redirect_valid) begin
                pend_cnt <= '0;
                drop_cnt <= drop_cnt + pend_cnt - CNT_W'(rsp_take);
                inst_cnt <= '0;
                inst_wr  <= '0;
                inst_rd  <= '0;
            end else begin
                pend_cnt <= pend_cnt + CNT_W'(req_fire)
                            - CNT_W'(rsp_take && (drop_cnt == '0));
                drop_cnt <= drop_cnt - CNT_W'(rsp_take && (drop_cnt != '0));
                inst_cnt <= inst_cnt + CNT_W'(rsp_keep) - CNT_W'(inst_pop);
                inst_wr  <= inst_wr + PTR_W'(rsp_keep);
                inst_rd  <= inst_rd + PTR_W'(inst_pop);
            end
        end
    end

    // Storage for pending request PCs and buffered instructions
    always_ff @(posedge clk) begin
        if (req_fire)
            pend_mem[pend_wr] <= imem_req_addr;
        if (rsp_keep) begin
            inst_pc_mem[inst_wr]   <= pend_mem[pend_rd];
            inst_data_mem[inst_wr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: models pc_register and a fixed-latency
// instruction memory whose word for address A is ~A.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    logic        man_v = 1'b0;
    logic [31:0] man_d = '0;
    logic        pipe_v [4];
    logic [31:0] pipe_a [4];

    fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_next(pc_next),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    // pc_register model
    always @(posedge clk) pc_cur <= pc_next;

    // Fixed-latency memory: accepted request appears on the response lat cycles later
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0] <= imem_req_valid && imem_req_ready;
            pipe_a[0] <= imem_req_addr;
            for (int i = 1; i < 4; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end

    assign imem_rsp_valid = pipe_v[lat-1] | man_v;
    assign imem_rsp_data  = man_v ? man_d : ~pipe_a[lat-1];

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        @(negedge clk); #1;
        checks++; if (pc_next !== RST_PC) begin errors++; $display("FAIL reset_pc_next got %h want %h", pc_next, RST_PC); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
        @(negedge clk);
        rst = 1'b0; #1;
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b want 1", imem_req_valid); end
        checks++; if (imem_req_addr !== RST_PC) begin errors++; $display("FAIL first_req_addr got %h want %h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] exp [3];
        int k = 0;
        exp[0] = 32'h8000_0000; exp[1] = 32'h8000_0004; exp[2] = 32'h8000_0008;
        lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 30 && k < 3; c++) begin
            @(negedge clk); #1;
            if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp[k] || inst_data !== ~exp[k]) begin
                    errors++; $display("FAIL stream_%0d got pc %h data %h want pc %h data %h", k, inst_pc, inst_data, exp[k], ~exp[k]);
                end
                k++;
            end
        end
        checks++; if (k != 3) begin errors++; $display("FAIL stream_timeout got %0d words want 3", k); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [4];
        int k = 0;
        exp[0] = 32'h8000_0000; exp[1] = 32'h8000_0004; exp[2] = 32'h8000_0008; exp[3] = 32'h8000_000C;
        lat = 1; inst_ready = 1'b0; imem_req_ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %b want 0", imem_req_valid); end
        checks++; if (pc_cur !== 32'h8000_0008) begin errors++; $display("FAIL stall_pc_hold got %h want 80000008", pc_cur); end
        checks++; if (pc_next !== 32'h8000_0008) begin errors++; $display("FAIL stall_pc_next got %h want 80000008", pc_next); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== exp[0]) begin errors++; $display("FAIL stall_head got v %b pc %h want v 1 pc %h", inst_valid, inst_pc, exp[0]); end
        inst_ready = 1'b1;
        #1;
        for (int c = 0; c < 30 && k < 4; c++) begin
            if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp[k] || inst_data !== ~exp[k]) begin
                    errors++; $display("FAIL resume_%0d got pc %h data %h want pc %h data %h", k, inst_pc, inst_data, exp[k], ~exp[k]);
                end
                k++;
            end
            @(negedge clk); #1;
        end
        checks++; if (k != 4) begin errors++; $display("FAIL resume_timeout got %0d words want 4", k); end
    endtask

    task automatic test_redirect();
        int k = 0;
        lat = 3; inst_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        repeat (2) @(negedge clk);
        // two requests accepted, neither answered yet
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; #1;
        checks++; if (pc_next !== 32'h8000_0100) begin errors++; $display("FAIL redir_pc_next got %h want 80000100", pc_next); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_req_valid got %b want 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (pc_cur !== 32'h8000_0100) begin errors++; $display("FAIL redir_pc_cur got %h want 80000100", pc_cur); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_wait_drop got %b want 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", inst_valid); end
        for (int c = 0; c < 30 && k < 1; c++) begin
            @(negedge clk); #1;
            if (inst_valid) begin
                checks++;
                if (inst_pc !== 32'h8000_0100 || inst_data !== ~32'h8000_0100) begin
                    errors++; $display("FAIL redir_first got pc %h data %h want pc 80000100 data %h", inst_pc, inst_data, ~32'h8000_0100);
                end
                k++;
            end
        end
        checks++; if (k != 1) begin errors++; $display("FAIL redir_timeout got %0d words want 1", k); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [2];
        int k = 0;
        exp[0] = 32'hFFFF_FFFC; exp[1] = 32'h0000_0000;
        lat = 1; inst_ready = 1'b1; imem_req_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b0; #1;
        checks++; if (pc_next !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_hold got %h want fffffffc", pc_next); end
        imem_req_ready = 1'b1; #1;
        checks++; if (pc_next !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc_next got %h want 00000000", pc_next); end
        checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req_addr got %h want fffffffc", imem_req_addr); end
        for (int c = 0; c < 30 && k < 2; c++) begin
            @(negedge clk); #1;
            if (inst_valid && inst_ready) begin
                checks++;
                if (inst_pc !== exp[k] || inst_data !== ~exp[k]) begin
                    errors++; $display("FAIL wrap_%0d got pc %h data %h want pc %h data %h", k, inst_pc, inst_data, exp[k], ~exp[k]);
                end
                k++;
            end
        end
        checks++; if (k != 2) begin errors++; $display("FAIL wrap_timeout got %0d words want 2", k); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        lat = 2; inst_ready = 1'b0; imem_req_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        // one word buffered, one request still in flight
        #1;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got %b want 1", inst_valid); end
        rst = 1'b1; #1;
        checks++; if (pc_next !== RST_PC) begin errors++; $display("FAIL mid_rst_pc got %h want %h", pc_next, RST_PC); end
        @(negedge clk);
        rst = 1'b0; inst_ready = 1'b1;
        man_v = 1'b1; man_d = 32'hDEAD_BEEF; #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_inst_valid got %b want 0", inst_valid); end
        checks++; if (imem_req_addr !== RST_PC || imem_req_valid !== 1'b1) begin errors++; $display("FAIL mid_restart got v %b addr %h want v 1 addr %h", imem_req_valid, imem_req_addr, RST_PC); end
        @(negedge clk);
        man_v = 1'b0; #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mid_late_rsp got %b want 0", inst_valid); end
        for (int c = 0; c < 30 && k < 1; c++) begin
            @(negedge clk); #1;
            if (inst_valid) begin
                checks++;
                if (inst_pc !== RST_PC || inst_data !== ~RST_PC) begin
                    errors++; $display("FAIL mid_first got pc %h data %h want pc %h data %h", inst_pc, inst_data, RST_PC, ~RST_PC);
                end
                k++;
            end
        end
        checks++; if (k != 1) begin errors++; $display("FAIL mid_timeout got %0d words want 1", k); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
